// File: rtl/Defines.sv
// Shared fixed-point, address and activation types for the inference datapath.
package Defines;

  typedef logic [15:0]        IntResAddr_t;
  typedef logic [15:0]        ParamAddr_t;
  typedef logic [9:0]         VectorLen_t;
  typedef logic signed [23:0] CompFx_t;

  typedef enum logic [1:0] {
    NO_ACTIVATION    = 2'd0,
    RELU_ACTIVATION  = 2'd1,
    SWISH_ACTIVATION = 2'd2
  } Activation_t;

endpackage

// File: rtl/dense_layer_sequencer.sv
// Walks the shared MAC unit through one dense layer, one output row per job,
// and writes each row result back to intermediate-result memory.
module dense_layer_sequencer
  import Defines::*;
#(
  parameter int unsigned MAX_ROWS = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  IntResAddr_t                    cfg_in_addr,
  input  ParamAddr_t                     cfg_kernel_addr,
  input  ParamAddr_t                     cfg_bias_addr,
  input  IntResAddr_t                    cfg_out_addr,
  input  VectorLen_t                     cfg_len,
  input  logic [$clog2(MAX_ROWS+1)-1:0]  cfg_num_rows,
  input  Activation_t                    cfg_act,
  output logic                           busy,
  output logic                           done,
  output logic                           mac_start,
  output IntResAddr_t                    mac_in_addr,
  output ParamAddr_t                     mac_kernel_addr,
  output ParamAddr_t                     mac_bias_addr,
  output VectorLen_t                     mac_len,
  output Activation_t                    mac_act,
  input  logic                           mac_done,
  input  CompFx_t                        mac_result,
  output logic                           wr_en,
  output IntResAddr_t                    wr_addr,
  output CompFx_t                        wr_data,
  input  logic                           wr_ready
);

  localparam int unsigned RowW = $clog2(MAX_ROWS + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StFinish} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] row_q, num_rows_q, row_inc;
  IntResAddr_t     in_addr_q, out_row_q, wr_addr_q;
  ParamAddr_t      kernel_addr_q, bias_addr_q;
  VectorLen_t      len_q;
  Activation_t     act_q;
  CompFx_t         wr_data_q;

  assign row_inc = row_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      row_q         <= '0;
      num_rows_q    <= '0;
      in_addr_q     <= '0;
      out_row_q     <= '0;
      wr_addr_q     <= '0;
      kernel_addr_q <= '0;
      bias_addr_q   <= '0;
      len_q         <= '0;
      act_q         <= NO_ACTIVATION;
      wr_data_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            row_q         <= '0;
            num_rows_q    <= cfg_num_rows;
            in_addr_q     <= cfg_in_addr;
            out_row_q     <= cfg_out_addr;
            kernel_addr_q <= cfg_kernel_addr;
            bias_addr_q   <= cfg_bias_addr;
            len_q         <= cfg_len;
            act_q         <= cfg_act;
          end
        end
        StWait: begin
          if (mac_done) begin
            wr_data_q <= mac_result;
            wr_addr_q <= out_row_q;
          end
        end
        StWrite: begin
          // Row addresses advance by accumulation; the kernel stride wraps with the address width.
          if (wr_ready) begin
            row_q         <= row_inc;
            kernel_addr_q <= kernel_addr_q + ParamAddr_t'(len_q);
            bias_addr_q   <= bias_addr_q + 1'b1;
            out_row_q     <= out_row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mac_start = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (cfg_num_rows == '0) ? StFinish : StIssue;
      end
      StIssue: begin
        busy      = 1'b1;
        mac_start = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (mac_done) state_d = StWrite;
      end
      StWrite: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (wr_ready) state_d = (row_inc == num_rows_q) ? StFinish : StIssue;
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mac_in_addr     = in_addr_q;
  assign mac_kernel_addr = kernel_addr_q;
  assign mac_bias_addr   = bias_addr_q;
  assign mac_len         = len_q;
  assign mac_act         = act_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer: the bench plays the MAC (fixed reply
// latency) and the memory (optional write stalls) and checks every handshake.
module tb_dense_layer_sequencer;
  import Defines::*;

  localparam int unsigned MaxRows = 64;
  localparam int unsigned RowW    = $clog2(MaxRows + 1);

  logic            clk = 1'b0;
  logic            rst_n, start, mac_done, wr_ready;
  IntResAddr_t     cfg_in_addr, cfg_out_addr;
  ParamAddr_t      cfg_kernel_addr, cfg_bias_addr;
  VectorLen_t      cfg_len;
  logic [RowW-1:0] cfg_num_rows;
  Activation_t     cfg_act;
  logic            busy, done, mac_start, wr_en;
  IntResAddr_t     mac_in_addr, wr_addr;
  ParamAddr_t      mac_kernel_addr, mac_bias_addr;
  VectorLen_t      mac_len;
  Activation_t     mac_act;
  CompFx_t         mac_result, wr_data;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_done = 0, n_acc = 0;
  int s0, d0, a0;

  dense_layer_sequencer #(.MAX_ROWS(MaxRows)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_addr(cfg_in_addr), .cfg_kernel_addr(cfg_kernel_addr),
    .cfg_bias_addr(cfg_bias_addr), .cfg_out_addr(cfg_out_addr),
    .cfg_len(cfg_len), .cfg_num_rows(cfg_num_rows), .cfg_act(cfg_act),
    .busy(busy), .done(done), .mac_start(mac_start),
    .mac_in_addr(mac_in_addr), .mac_kernel_addr(mac_kernel_addr),
    .mac_bias_addr(mac_bias_addr), .mac_len(mac_len), .mac_act(mac_act),
    .mac_done(mac_done), .mac_result(mac_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mac_start) n_start <= n_start + 1;
    if (done) n_done <= n_done + 1;
    if (wr_en && wr_ready) n_acc <= n_acc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input IntResAddr_t in_a, input ParamAddr_t k, input ParamAddr_t b,
                           input IntResAddr_t o, input VectorLen_t len, input int rows,
                           input Activation_t act);
    s0 = n_start;
    d0 = n_done;
    a0 = n_acc;
    cfg_in_addr     = in_a;
    cfg_kernel_addr = k;
    cfg_bias_addr   = b;
    cfg_out_addr    = o;
    cfg_len         = len;
    cfg_num_rows    = rows[RowW-1:0];
    cfg_act         = act;
    start           = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the ISSUE cycle; MAC replies 5 cycles after mac_start; leaves the
  // cycle after the write is accepted.
  task automatic do_row(input int r, input IntResAddr_t in_a, input ParamAddr_t kexp,
                        input ParamAddr_t bexp, input IntResAddr_t oexp, input VectorLen_t len,
                        input Activation_t act, input CompFx_t res, input int stall,
                        input bit poke);
    chk($sformatf("r%0d mac_start", r), mac_start, 1'b1);
    chk($sformatf("r%0d busy", r), busy, 1'b1);
    chk($sformatf("r%0d mac_kernel_addr", r), mac_kernel_addr, kexp);
    chk($sformatf("r%0d mac_bias_addr", r), mac_bias_addr, bexp);
    chk($sformatf("r%0d mac_in_addr", r), mac_in_addr, in_a);
    chk($sformatf("r%0d mac_len", r), mac_len, len);
    chk($sformatf("r%0d mac_act", r), mac_act, act);
    tick();
    chk($sformatf("r%0d mac_start low in wait", r), mac_start, 1'b0);
    if (poke) begin
      start           = 1'b1;
      cfg_in_addr     = 16'hBEEF;
      cfg_kernel_addr = 16'h1234;
      cfg_bias_addr   = 16'h4321;
      cfg_out_addr    = 16'h0F0F;
      cfg_len         = 10'd3;
      cfg_num_rows    = 7'd1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk($sformatf("r%0d kernel after poke", r), mac_kernel_addr, kexp);
      chk($sformatf("r%0d in after poke", r), mac_in_addr, in_a);
      chk($sformatf("r%0d busy after poke", r), busy, 1'b1);
    end else begin
      repeat (4) tick();
    end
    chk($sformatf("r%0d kernel held in wait", r), mac_kernel_addr, kexp);
    chk($sformatf("r%0d bias held in wait", r), mac_bias_addr, bexp);
    mac_done   = 1'b1;
    mac_result = res;
    if (stall > 0) wr_ready = 1'b0;
    tick();
    mac_done = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk($sformatf("r%0d stall%0d wr_en", r, s), wr_en, 1'b1);
      chk($sformatf("r%0d stall%0d wr_addr", r, s), wr_addr, oexp);
      chk($sformatf("r%0d stall%0d wr_data", r, s), wr_data, res);
      chk($sformatf("r%0d stall%0d mac_start", r, s), mac_start, 1'b0);
      tick();
    end
    wr_ready = 1'b1;
    chk($sformatf("r%0d wr_en", r), wr_en, 1'b1);
    chk($sformatf("r%0d wr_addr", r), wr_addr, oexp);
    chk($sformatf("r%0d wr_data", r), wr_data, res);
    tick();
  endtask

  task automatic run_job(input IntResAddr_t in_a, input ParamAddr_t k, input ParamAddr_t b,
                         input IntResAddr_t o, input VectorLen_t len, input int rows,
                         input Activation_t act, input int stall_row, input int poke_row,
                         input int res_base);
    start_job(in_a, k, b, o, len, rows, act);
    for (int r = 0; r < rows; r++) begin
      do_row(r, in_a, ParamAddr_t'(int'(k) + r * int'(len)), ParamAddr_t'(int'(b) + r),
             IntResAddr_t'(int'(o) + r), len, act, CompFx_t'(res_base + r * 37),
             (r == stall_row) ? 4 : 0, r == poke_row);
    end
    chk("job done pulse", done, 1'b1);
    chk("job busy low at done", busy, 1'b0);
    chk("job no mac_start at done", mac_start, 1'b0);
    tick();
    chk("job done one cycle", done, 1'b0);
    chk("job mac_start count", n_start - s0, rows);
    chk("job done count", n_done - d0, 1);
    chk("job write count", n_acc - a0, rows);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mac_done = 1'b0; mac_result = '0; wr_ready = 1'b1;
    cfg_in_addr = '0; cfg_kernel_addr = '0; cfg_bias_addr = '0; cfg_out_addr = '0;
    cfg_len = '0; cfg_num_rows = '0; cfg_act = NO_ACTIVATION;
    repeat (2) tick();
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst mac_start", mac_start, 1'b0);
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst mac_kernel_addr", mac_kernel_addr, 16'd0);
    chk("rst mac_bias_addr", mac_bias_addr, 16'd0);
    chk("rst wr_addr", wr_addr, 16'd0);
    chk("rst wr_data", wr_data, 24'd0);
    rst_n = 1'b1;
    tick();
    chk("idle busy", busy, 1'b0);

    // Basic job: kernel 8000/8064/8128, bias 30944..30946, out 20000..20002.
    run_job(16'd0, 16'd8000, 16'd30944, 16'd20000, 10'd64, 3, NO_ACTIVATION, -1, -1, 1000);

    // Spurious mac_done while idle.
    mac_done = 1'b1; mac_result = 24'h00ABCD;
    tick();
    mac_done = 1'b0;
    chk("spurious wr_en", wr_en, 1'b0);
    chk("spurious busy", busy, 1'b0);
    tick();
    chk("spurious wr_en later", wr_en, 1'b0);

    // Backpressure on row 1, ignored start with new cfg during row 0 WAIT.
    run_job(16'd40, 16'd500, 16'd600, 16'd700, 10'd10, 3, SWISH_ACTIVATION, 1, 0, -50);

    // Zero rows: done straight away, nothing issued.
    start_job(16'd1, 16'd2, 16'd3, 16'd4, 10'd5, 0, NO_ACTIVATION);
    chk("zero done", done, 1'b1);
    chk("zero busy", busy, 1'b0);
    chk("zero mac_start", mac_start, 1'b0);
    tick();
    chk("zero done cleared", done, 1'b0);
    tick();
    chk("zero mac_start count", n_start - s0, 0);
    chk("zero write count", n_acc - a0, 0);
    chk("zero done count", n_done - d0, 1);

    // Reset during WAIT of row 2 of 4.
    start_job(16'd5, 16'd100, 16'd200, 16'd300, 10'd16, 4, RELU_ACTIVATION);
    do_row(0, 16'd5, 16'd100, 16'd200, 16'd300, 10'd16, RELU_ACTIVATION, 24'd11, 0, 1'b0);
    do_row(1, 16'd5, 16'd116, 16'd201, 16'd301, 10'd16, RELU_ACTIVATION, 24'd22, 0, 1'b0);
    chk("r2 mac_start before reset", mac_start, 1'b1);
    chk("r2 kernel before reset", mac_kernel_addr, 16'd132);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort mac_start", mac_start, 1'b0);
    chk("abort wr_en", wr_en, 1'b0);
    chk("abort mac_in_addr", mac_in_addr, 16'd0);
    chk("abort mac_kernel_addr", mac_kernel_addr, 16'd0);
    chk("abort mac_bias_addr", mac_bias_addr, 16'd0);
    chk("abort mac_len", mac_len, 10'd0);
    chk("abort mac_act", mac_act, NO_ACTIVATION);
    chk("abort wr_addr", wr_addr, 16'd0);
    chk("abort wr_data", wr_data, 24'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mac_done = 1'b1; mac_result = 24'h000BAD;
    tick();
    mac_done = 1'b0;
    chk("late mac_done wr_en", wr_en, 1'b0);
    chk("late mac_done busy", busy, 1'b0);
    tick();
    chk("late mac_done wr_en later", wr_en, 1'b0);
    chk("abort write count", n_acc - a0, 2);
    run_job(16'd9, 16'd4000, 16'd4100, 16'd4200, 10'd8, 2, NO_ACTIVATION, -1, -1, 300);

    // Maximum rows: last kernel address 1000 + 63*32 = 3016.
    run_job(16'd3, 16'd1000, 16'd2000, 16'd100, 10'd32, 64, SWISH_ACTIVATION, -1, -1, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
